imem_loader: RTL
================

# imem_loader

Boot-time writer for the instruction memory. It accepts a framed byte stream on a valid/ready interface and assembles little-endian 32-bit words. It writes them through the instruction-memory write port and holds the CPU in reset until the image is complete and checked. It is the write-side counterpart of the read-only instruction fetch path: word index = byte address[15:2], 16384 words.

## Interface
- `DEPTH`, 16384: instruction memory depth in words; the maximum legal word count.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles between accepted bytes while a load is active.
- `BOOT_HOLD`, 0: reset value of `cpu_hold` (1 = CPU held from reset until the first successful load).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; ignored unless in IDLE, DONE or ERROR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs when `rx_valid && rx_ready`.
- `mem_we`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  32  byte address, always word aligned (bits [1:0] = 0).
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  CPU reset hold.
- `done`  out  1  load completed and checksum matched.
- `error`  out  1  load aborted.
- `err_code`  out  2  1 = bad count, 2 = checksum mismatch, 3 = timeout; 0 when `error`=0.

## Operation
- Frame format:
  - 4-byte little-endian word count N.
  - N words of 4 bytes each, little-endian (first byte goes to [7:0]).
  - 1 checksum byte equal to the XOR of all 4N payload bytes. The count bytes are excluded.
- States: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + `start`:
  - go to COUNT.
  - clear `done`, `error`, `err_code`, the byte index, word index, checksum and timeout counter.
  - set `cpu_hold`=1.
- COUNT: accept 4 bytes.
  - On the 4th byte, N=0 or N>DEPTH → ERROR, code 1.
  - Otherwise → DATA.
- DATA: each accepted byte XORs into the checksum and shifts into the word assembler. On the 4th byte of a word:
  - the word is issued as a write.
  - the word index increments.
  - after word N → CHECK.
- CHECK: accept 1 byte.
  - If it equals the checksum → DONE: `done`=1, `cpu_hold`=0.
  - Otherwise → ERROR, code 2.
- ERROR: `cpu_hold` stays 1, `error`=1. Words already written are not rolled back.
- Timeout: a counter runs in COUNT/DATA/CHECK and clears on every accepted byte. On reaching TIMEOUT_CYCLES → ERROR, code 3. If a byte is accepted in the same cycle the limit is reached, the byte wins and the counter clears.
- `start` in COUNT/DATA/CHECK is ignored; no restart mid-frame.
- Words beyond N are never written. Write addresses never wrap because N≤DEPTH.

## Timing
- Reset values:
  - `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `done`=0, `error`=0, `err_code`=0.
  - `cpu_hold`=BOOT_HOLD; state IDLE.
- Reset mid-load aborts immediately: state IDLE, all outputs return to their reset values.
- `rx_ready` is registered: it is 1 in every cycle of COUNT/DATA/CHECK and 0 otherwise. There is no backpressure from memory; sustained throughput is 1 byte/cycle.
- `rx_ready` enters COUNT one cycle after `start` is sampled.
- `mem_we` pulses for exactly one cycle. The pulse is the cycle after the 4th byte of a word is accepted, with `mem_addr` = word_index×4 and `mem_wdata` valid in that cycle. `mem_addr`/`mem_wdata` hold their values afterward.
- `done`/`error` assert the cycle after the deciding byte (or timeout) and are held until the next `start` or reset. `cpu_hold` drops in the same cycle `done` rises.
- The final data word's `mem_we` is at least one cycle before `done`.

## Structure
- `imem_loader_pkg`: state enum, `ERR_NONE`/`ERR_COUNT`/`ERR_CSUM`/`ERR_TIMEOUT` constants, and the frame byte counts (count=4, csum=1).
- Sub-module `byte_word_packer`:
  - 4-byte little-endian shift assembler with a 2-bit byte counter.
  - Outputs a `word_valid` pulse and the word; has a clear input.
  - Used for both the count field and the data words.
- The FSM, checksum, word index and timeout counter live in the top level.

## Test plan
- Frame N=2, words 0x00000013, 0xDEADBEEF, csum 0x13^0xDE^0xAD^0xBE^0xEF → writes (0x0,0x00000013), (0x4,0xDEADBEEF); `done`=1, `cpu_hold`=0.
- Same frame with checksum byte XOR 0x01 → both words written; `error`=1, `err_code`=2, `cpu_hold`=1.
- Count N=0, and separately N=16385 → ERROR code 1 after the 4th count byte; no `mem_we`.
- N=1; stall `rx_valid` low for TIMEOUT_CYCLES (set to 8) after 2 data bytes → ERROR code 3. Repeat with a byte arriving on cycle 8 → no error.
- `start` pulsed mid-DATA → ignored, load completes normally. Assert `rst_n`=0 mid-word → all outputs at reset values, no further `mem_we`.
- Full N=16384 load with random data and `rx_valid` gaps → last write at `mem_addr`=0xFFFC; memory contents match the stream; `done`=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_e     : loader FSM states
//   ERR_*       : err_code encodings
//   COUNT_BYTES : bytes in the word-count field (also bytes per data word)
//   CSUM_BYTES  : bytes in the trailing checksum field
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_COUNT   = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int unsigned COUNT_BYTES = 4;
  localparam int unsigned CSUM_BYTES  = 1;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_active(state_e s);
    return (s == ST_COUNT) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Little-endian byte-to-word assembler; the first byte lands in [7:0].
//   clk, rst_n     : clock, async active-low reset
//   clr_i          : drop any partial word and restart at byte 0
//   en_i           : a byte is being accepted this cycle
//   byte_i         : the accepted byte
//   word_valid_c_o : combinational, high while the 4th byte of a word is accepted
//   word_c_o       : combinational, the completed word (valid with word_valid_c_o)
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_c_o,
  output logic [31:0] word_c_o
);

  localparam int unsigned CNT_W = $clog2(COUNT_BYTES);
  localparam int unsigned SR_W  = 8 * (COUNT_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q,  sr_d;

  // Bytes shift in from the top so earlier bytes settle in the low lanes.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      sr_d  = {byte_i, sr_q[SR_W-1:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word_c_o       = {byte_i, sr_q};
  assign word_valid_c_o = en_i && !clr_i && (cnt_q == CNT_W'(COUNT_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: consumes a framed byte stream
// (count, little-endian words, XOR checksum), writes each word and holds
// the CPU in reset until the image is complete and verified.
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a load (only honoured in IDLE/DONE/ERROR)
//   rx_data/rx_valid  : byte stream in; rx_ready accepts it
//   mem_we/addr/wdata : one-cycle instruction-memory write
//   cpu_hold          : CPU reset hold
//   done/error        : sticky completion / abort status; err_code qualifies error
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic        BOOT_HOLD      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int unsigned IDX_W  = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CSUM_W = 8 * CSUM_BYTES;

  state_e            state_q,     state_d;
  logic              rx_ready_q,  rx_ready_d;
  logic              mem_we_q,    mem_we_d;
  logic [31:0]       mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q,  cpu_hold_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;
  logic [1:0]        err_code_q,  err_code_d;
  logic [CSUM_W-1:0] csum_q,      csum_d;
  logic [IDX_W-1:0]  widx_q,      widx_d;
  logic [IDX_W-1:0]  nwords_q,    nwords_d;
  logic [TMO_W-1:0]  tmo_q,       tmo_d;

  logic        accept_c;
  logic        start_ok_c;
  logic        pk_en_c;
  logic        word_valid_c;
  logic [31:0] word_c;

  assign accept_c   = rx_valid && rx_ready_q;
  assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERROR));
  assign pk_en_c    = accept_c && ((state_q == ST_COUNT) || (state_q == ST_DATA));

  // Shared assembler: the count field and every data word are 4 LE bytes.
  byte_word_packer u_packer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_i          (start_ok_c),
    .en_i           (pk_en_c),
    .byte_i         (rx_data),
    .word_valid_c_o (word_valid_c),
    .word_c_o       (word_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    csum_d      = csum_q;
    widx_d      = widx_q;
    nwords_d    = nwords_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_COUNT;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          csum_d     = '0;
          widx_d     = '0;
          tmo_d      = '0;
          cpu_hold_d = 1'b1;
        end
      end
      ST_COUNT: begin
        if (word_valid_c) begin
          if ((word_c == 32'd0) || (word_c > 32'(DEPTH))) begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_COUNT;
          end else begin
            nwords_d = IDX_W'(word_c);
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          csum_d = csum_q ^ rx_data;
          if (word_valid_c) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = 32'(widx_q) << 2;
            mem_wdata_d = word_c;
            widx_d      = widx_q + IDX_W'(1);
            if (widx_d == nwords_q) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (accept_c) begin
          if (rx_data == csum_q) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inactivity watchdog; an accepted byte always beats the limit.
    if (is_active(state_q)) begin
      if (accept_c) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d    = ST_ERROR;
        error_d    = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    // Ready tracks the state being entered so it is high for every active cycle.
    rx_ready_d = is_active(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= BOOT_HOLD;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      csum_q      <= '0;
      widx_q      <= '0;
      nwords_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      csum_q      <= csum_d;
      widx_q      <= widx_d;
      nwords_q    <= nwords_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule
